sdram_rw_arb: RTL
=================

SDRAM_RW_ARB -- requirements
Module: sdram_rw_arb

Interface
REQ-001 SHALL have parameter REF_PERIOD, 781, clk cycles between refresh requests (7.8 us at 100 MHz).
REQ-002 SHALL have parameter STARVE_MAX, 4, consecutive write grants allowed while a read is eligible.
REQ-003 SHALL have parameter LEN_W, 10, width of burst-length and FIFO-level ports.
REQ-004 SHALL have port clk  in  1  single clock (SDRAM controller reference clock); all logic is on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port init_done  in  1  SDRAM initialisation complete; level.
REQ-007 SHALL have ports wr_fifo_used, rd_fifo_used  in  LEN_W  write-FIFO fill level and read-FIFO fill level.
REQ-008 SHALL have ports wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr  in  23  word-address window per direction.
REQ-009 SHALL have ports wr_len, rd_len  in  LEN_W  burst lengths, nonzero.
REQ-010 SHALL have ports wr_load, rd_load  in  1  one-cycle pulses that restart the write or read address stream.
REQ-011 SHALL have ports read_valid, pingpang_en  in  1  read enable; ping-pong buffering enable.
REQ-012 SHALL have ports cmd_ack, cmd_done  in  1  controller accepted the command; burst finished (one-cycle pulses).
REQ-013 SHALL have ports cmd_req  out  1, cmd_type  out  2 (01 refresh, 10 write, 11 read), cmd_addr  out  24, cmd_len  out  LEN_W.
REQ-014 SHALL have port ref_overrun  out  1  sticky flag: refresh period expired while a refresh was still pending.

Function
REQ-015 SHALL use FSM states INIT, IDLE, REQ and BUSY; INIT->IDLE when init_done=1; IDLE->REQ when any request is eligible; REQ->BUSY on cmd_ack; BUSY->IDLE on cmd_done.
REQ-016 SHALL treat a write as eligible when wr_fifo_used >= wr_len, and a read as eligible when read_valid=1 and rd_fifo_used < rd_len.
REQ-017 SHALL hold the refresh counter at 0 in INIT; after INIT it counts 0..REF_PERIOD-1, wraps, and sets ref_pend on each wrap.
REQ-018 SHALL clear ref_pend on the cmd_ack of a refresh command; a wrap while ref_pend=1 SHALL set ref_overrun, which only rst clears.
REQ-019 SHALL grant by priority refresh > write > read, with the starvation override in REQ-031.
REQ-020 SHALL assert cmd_req the cycle after the IDLE decision, hold cmd_type, cmd_addr and cmd_len stable until cmd_ack is sampled, and deassert cmd_req in the cycle after ack.
REQ-021 SHALL drive cmd_len=0 for refresh and cmd_addr={bank,addr} for write and read, with bank=wr_bank or rd_bank.
REQ-022 SHALL, on cmd_done of a write, advance wr_addr by wr_len; when wr_addr+wr_len >= wr_max_addr, wr_addr SHALL wrap to wr_min_addr and, if pingpang_en=1, wr_bank SHALL toggle.
REQ-023 SHALL, on a read wrap, set rd_addr to rd_min_addr and, if pingpang_en=1, set rd_bank to ~wr_bank (read the buffer that is not being written); without ping-pong, rd_bank=wr_bank=0.
REQ-024 SHALL apply a wr_load or rd_load pulse in IDLE or INIT immediately: address to min, wr_bank to 0, rd_bank to 1 (0 when pingpang_en=0).
REQ-025 SHALL, when a load arrives in REQ or BUSY for the same direction, latch it and apply it at cmd_done instead of the address advance; load SHALL win over a simultaneous wrap.
REQ-026 SHALL ignore cmd_ack outside REQ and cmd_done outside BUSY.
REQ-027 SHALL return to INIT with cmd_req=0 if init_done falls, after any in-flight BUSY completes.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state INIT, cmd_req=0, cmd_type=00, cmd_addr=0, cmd_len=0 and ref_overrun=0.
REQ-029 SHALL, on reset, also clear wr_addr, rd_addr, wr_bank, the refresh counter, ref_pend, the latched loads and the starvation counter, and set rd_bank=1.
REQ-030 SHALL let reset asserted mid-burst abort immediately with no further cmd_req; controller recovery is outside this block.

Configuration
REQ-031 SHALL, with macro SDRAM_ARB_STARVE_EN defined, count consecutive write grants made while a read is eligible, grant the read once the count reaches STARVE_MAX (refresh still first), and clear the count on any read grant.
REQ-032 SHALL, without SDRAM_ARB_STARVE_EN, use strict refresh > write > read with no starvation counter logic.

Verification
REQ-033 SHALL cover: init_done rises, wr_fifo_used=512, wr_len=512 -> cmd_req high 2 cycles later, cmd_type=10, cmd_addr=0, cmd_len=512.
REQ-034 SHALL cover: REF_PERIOD=781 with a write and a read both eligible at the refresh wrap -> the next grant is cmd_type=01, and two wraps without ack -> ref_overrun=1.
REQ-035 SHALL cover: wr_max_addr=130560, wr_len=512 with pingpang_en=1, running 255 write bursts -> wr_addr returns to 0, wr_bank toggles, and the next read wrap gives rd_bank=~wr_bank.
REQ-036 SHALL cover: wr_load pulsed during BUSY at wr_addr=1024 -> after cmd_done, wr_addr=0 and wr_bank=0.
REQ-037 SHALL cover: with STARVE_EN defined, STARVE_MAX=4 and writes and reads permanently eligible -> the grant pattern is W,W,W,W,R repeating; with the macro undefined -> writes only.

Source files
------------

// File: rtl/sdram_rw_arb.sv
// sdram_rw_arb: arbitrates refresh, write-burst and read-burst commands for an SDRAM controller.
// Define SDRAM_ARB_STARVE_EN to let a waiting read pre-empt writes after STARVE_MAX write grants.
module sdram_rw_arb #(
    parameter int REF_PERIOD = 781,
    parameter int STARVE_MAX = 4,
    parameter int LEN_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_done,
    input  logic [LEN_W-1:0] wr_fifo_used,
    input  logic [LEN_W-1:0] rd_fifo_used,
    input  logic [22:0]      wr_min_addr,
    input  logic [22:0]      wr_max_addr,
    input  logic [22:0]      rd_min_addr,
    input  logic [22:0]      rd_max_addr,
    input  logic [LEN_W-1:0] wr_len,
    input  logic [LEN_W-1:0] rd_len,
    input  logic             wr_load,
    input  logic             rd_load,
    input  logic             read_valid,
    input  logic             pingpang_en,
    input  logic             cmd_ack,
    input  logic             cmd_done,
    output logic             cmd_req,
    output logic [1:0]       cmd_type,
    output logic [23:0]      cmd_addr,
    output logic [LEN_W-1:0] cmd_len,
    output logic             ref_overrun,
    output logic [1:0]       fsm_state
);
    localparam int RC_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [1:0] T_REF = 2'b01;
    localparam logic [1:0] T_WR  = 2'b10;
    localparam logic [1:0] T_RD  = 2'b11;

    // Handshake: cmd_req rises with cmd_type/cmd_addr/cmd_len valid and holds them until cmd_ack
    // is sampled in REQ; cmd_done in BUSY ends the burst. cmd_ack/cmd_done are ignored elsewhere.
    typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, REQ = 2'd2, BUSY = 2'd3} state_t;
    state_t state, state_next;

    logic [RC_W-1:0] ref_cnt;
    logic            ref_pend;
    logic [22:0]     wr_addr, rd_addr, wr_addr_eff, rd_addr_eff;
    logic            wr_bank, rd_bank, wr_bank_eff, rd_bank_eff;
    logic            wr_load_pend, rd_load_pend, wr_ld, rd_ld;
    logic            wr_elig, rd_elig, any_elig, starve_hit;
    logic            grant_ref, grant_wr, grant_rd, decide;
    logic            quiet, busy_done, wr_done, rd_done, ref_ack, wr_wrap, rd_wrap;

    assign wr_elig  = wr_fifo_used >= wr_len;
    assign rd_elig  = read_valid && (rd_fifo_used < rd_len);
    assign any_elig = ref_pend || wr_elig || rd_elig;

`ifdef SDRAM_ARB_STARVE_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0] starve_cnt;

    assign starve_hit = rd_elig && (starve_cnt >= SC_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (decide) begin
            if (grant_rd || (grant_wr && !rd_elig)) starve_cnt <= '0;
            else if (grant_wr) starve_cnt <= starve_cnt + SC_W'(1);
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        grant_ref = ref_pend;
        grant_wr  = !ref_pend && wr_elig && !starve_hit;
        grant_rd  = !ref_pend && rd_elig && (starve_hit || !wr_elig);
    end

    always_comb begin
        state_next = state;
        decide     = 1'b0;
        case (state)
            INIT: if (init_done) state_next = IDLE;
            IDLE: begin
                if (!init_done) begin
                    state_next = INIT;
                end else if (any_elig) begin
                    state_next = REQ;
                    decide     = 1'b1;
                end
            end
            REQ: begin
                if (cmd_ack) state_next = BUSY;
                else if (!init_done) state_next = INIT;
            end
            BUSY:    if (cmd_done) state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    assign fsm_state = state;
    assign quiet     = (state == INIT) || (state == IDLE);
    assign busy_done = (state == BUSY) && cmd_done;
    assign wr_done   = busy_done && (cmd_type == T_WR);
    assign rd_done   = busy_done && (cmd_type == T_RD);
    assign ref_ack   = (state == REQ) && cmd_ack && (cmd_type == T_REF);
    assign wr_ld     = wr_load || wr_load_pend;
    assign rd_ld     = rd_load || rd_load_pend;
    assign wr_wrap   = ({1'b0, wr_addr} + 24'(wr_len)) >= {1'b0, wr_max_addr};
    assign rd_wrap   = ({1'b0, rd_addr} + 24'(rd_len)) >= {1'b0, rd_max_addr};

    // A load seen in IDLE applies this cycle, so a grant issued alongside it uses the min address.
    assign wr_addr_eff = wr_ld ? wr_min_addr : wr_addr;
    assign wr_bank_eff = wr_ld ? 1'b0 : wr_bank;
    assign rd_addr_eff = rd_ld ? rd_min_addr : rd_addr;
    assign rd_bank_eff = rd_ld ? pingpang_en : rd_bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_req  <= 1'b0;
            cmd_type <= 2'b00;
            cmd_addr <= '0;
            cmd_len  <= '0;
        end else if (decide) begin
            cmd_req <= 1'b1;
            if (grant_ref) begin
                cmd_type <= T_REF;
                cmd_addr <= '0;
                cmd_len  <= '0;
            end else if (grant_wr) begin
                cmd_type <= T_WR;
                cmd_addr <= {wr_bank_eff & pingpang_en, wr_addr_eff};
                cmd_len  <= wr_len;
            end else if (grant_rd) begin
                cmd_type <= T_RD;
                cmd_addr <= {rd_bank_eff & pingpang_en, rd_addr_eff};
                cmd_len  <= rd_len;
            end
        end else if ((state == REQ) && (cmd_ack || !init_done)) begin
            cmd_req <= 1'b0;
        end
    end

    // A wrap that finds the previous refresh still unserved is an overrun; the ack on the same
    // edge counts as served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            if (ref_ack) ref_pend <= 1'b0;
            if (state == INIT) begin
                ref_cnt <= '0;
            end else if (ref_cnt == RC_W'(REF_PERIOD - 1)) begin
                ref_cnt  <= '0;
                ref_pend <= 1'b1;
                if (ref_pend && !ref_ack) ref_overrun <= 1'b1;
            end else begin
                ref_cnt <= ref_cnt + RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr      <= '0;
            wr_bank      <= 1'b0;
            wr_load_pend <= 1'b0;
        end else if ((quiet || busy_done) && wr_ld) begin
            wr_addr      <= wr_min_addr;
            wr_bank      <= 1'b0;
            wr_load_pend <= 1'b0;
        end else if (wr_done) begin
            if (wr_wrap) begin
                wr_addr <= wr_min_addr;
                if (pingpang_en) wr_bank <= ~wr_bank;
            end else begin
                wr_addr <= wr_addr + 23'(wr_len);
            end
        end else if (wr_load) begin
            wr_load_pend <= 1'b1;
        end
    end

    // On a read wrap, switch to the half that the writer is not currently filling.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr      <= '0;
            rd_bank      <= 1'b1;
            rd_load_pend <= 1'b0;
        end else if ((quiet || busy_done) && rd_ld) begin
            rd_addr      <= rd_min_addr;
            rd_bank      <= pingpang_en;
            rd_load_pend <= 1'b0;
        end else if (rd_done) begin
            if (rd_wrap) begin
                rd_addr <= rd_min_addr;
                rd_bank <= pingpang_en ? ~wr_bank : 1'b0;
            end else begin
                rd_addr <= rd_addr + 23'(rd_len);
            end
        end else if (rd_load) begin
            rd_load_pend <= 1'b1;
        end
    end
endmodule
